// File: rtl/extrema_pkg.sv
// Shared types and constants for the streaming min/max frame reducer.
package extrema_pkg;
  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic MODE_MIN = 1'b0;
  localparam logic MODE_MAX = 1'b1;
endpackage

// File: rtl/extrema_cmp.sv
// Strict compare of a candidate word against the running extreme; ties report 0.
module extrema_cmp
  import extrema_pkg::*;
#(
  parameter int WORD_WIDTH = 8,
  parameter int SIGNED     = 0
) (
  input  logic [WORD_WIDTH-1:0] cand,
  input  logic [WORD_WIDTH-1:0] best,
  input  logic                  mode,
  output logic                  better
);
  logic lt;
  logic gt;

  always_comb begin
    if (SIGNED != 0) begin
      lt = $signed(cand) < $signed(best);
      gt = $signed(cand) > $signed(best);
    end else begin
      lt = cand < best;
      gt = cand > best;
    end
    better = (mode == MODE_MAX) ? gt : lt;
  end
endmodule

// File: rtl/stream_extrema.sv
// Reduces each DATA_LEN-word frame to its min or max word and that word's index.
module stream_extrema
  import extrema_pkg::*;
#(
  parameter  int WORD_WIDTH = 8,
  parameter  int DATA_LEN   = 16,
  parameter  int SIGNED     = 0,
  localparam int IDX_W      = $clog2(DATA_LEN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_data,
  output logic [IDX_W-1:0]      out_idx
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DATA_LEN - 1);

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0] best_q, best_d;
  logic [IDX_W-1:0]      best_idx_q, best_idx_d;
  logic                  mode_q, mode_d;
  logic [WORD_WIDTH-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0]      out_idx_q, out_idx_d;
  logic                  better;
  logic                  accept;

  extrema_cmp #(
    .WORD_WIDTH(WORD_WIDTH),
    .SIGNED    (SIGNED)
  ) u_cmp (
    .cand  (in_data),
    .best  (best_q),
    .mode  (mode_q),
    .better(better)
  );

  assign in_ready  = (state_q == ACC) && !rst;
  assign out_valid = (state_q == HOLD);
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    mode_d     = mode_q;
    out_data_d = out_data_q;
    out_idx_d  = out_idx_q;
    if (clr) begin
      state_d = ACC;
      cnt_d   = '0;
    end else if (state_q == ACC) begin
      if (accept) begin
        // The first beat seeds the extreme and latches the frame's mode.
        if (cnt_q == '0) begin
          best_d     = in_data;
          best_idx_d = '0;
          mode_d     = mode;
        end else if (better) begin
          best_d     = in_data;
          best_idx_d = cnt_q;
        end
        if (cnt_q == LAST) begin
          cnt_d      = '0;
          state_d    = HOLD;
          out_data_d = best_d;
          out_idx_d  = best_idx_d;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end else if (out_valid && out_ready) begin
      state_d = ACC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ACC;
      cnt_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      mode_q     <= MODE_MIN;
      out_data_q <= '0;
      out_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      mode_q     <= mode_d;
      out_data_q <= out_data_d;
      out_idx_q  <= out_idx_d;
    end
  end
endmodule

// File: tb/tb_stream_extrema.sv
// Directed bench: an unsigned and a signed instance share one stimulus stream.
module tb_stream_extrema;
  logic       clk = 1'b0;
  logic       rst, clr, mode, in_valid, out_ready;
  logic [7:0] in_data;
  logic       u_in_ready, u_out_valid, s_in_ready, s_out_valid;
  logic [7:0] u_out_data, s_out_data;
  logic [3:0] u_out_idx, s_out_idx;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stream_extrema #(.WORD_WIDTH(8), .DATA_LEN(16), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .clr(clr), .mode(mode),
    .in_valid(in_valid), .in_ready(u_in_ready), .in_data(in_data),
    .out_valid(u_out_valid), .out_ready(out_ready),
    .out_data(u_out_data), .out_idx(u_out_idx)
  );

  stream_extrema #(.WORD_WIDTH(8), .DATA_LEN(16), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .clr(clr), .mode(mode),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .out_idx(s_out_idx)
  );

  typedef struct packed {
    logic         m;
    logic [127:0] w;
    logic [7:0]   eu_d;
    logic [3:0]   eu_i;
    logic [7:0]   es_d;
    logic [3:0]   es_i;
  } vec_t;

  vec_t       tbl [6];
  logic [7:0] cur [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives cur[] as one back-to-back frame; mode flips after beat 0 when toggle is set.
  task automatic send_frame(input logic m, input logic toggle);
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_data  = cur[i];
      mode     = (toggle && i > 0) ? ~m : m;
      tick();
      if (i == 14) check("valid_before_last", {31'd0, u_out_valid}, 32'd0);
    end
    in_valid = 1'b0;
    check("valid_after_last", {31'd0, u_out_valid}, 32'd1);
    check("ready_in_hold", {31'd0, u_in_ready}, 32'd0);
  endtask

  task automatic ack();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("valid_after_ack", {31'd0, u_out_valid}, 32'd0);
    check("ready_after_ack", {31'd0, u_in_ready}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) tbl[0].w[i*8 +: 8] = 8'(16 - i);
    tbl[0].m = 1'b0; tbl[0].eu_d = 8'h01; tbl[0].eu_i = 4'd15; tbl[0].es_d = 8'h01; tbl[0].es_i = 4'd15;
    for (int i = 0; i < 16; i++) tbl[1].w[i*8 +: 8] = 8'h05;
    tbl[1].w[3*8 +: 8] = 8'hF0; tbl[1].w[9*8 +: 8] = 8'hF0;
    tbl[1].m = 1'b1; tbl[1].eu_d = 8'hF0; tbl[1].eu_i = 4'd3; tbl[1].es_d = 8'h05; tbl[1].es_i = 4'd0;
    for (int i = 0; i < 16; i++) tbl[2].w[i*8 +: 8] = 8'h10;
    tbl[2].w[7:0] = 8'h7F; tbl[2].w[15:8] = 8'h80; tbl[2].w[23:16] = 8'h00;
    tbl[2].m = 1'b0; tbl[2].eu_d = 8'h00; tbl[2].eu_i = 4'd2; tbl[2].es_d = 8'h80; tbl[2].es_i = 4'd1;
    for (int i = 0; i < 16; i++) tbl[3].w[i*8 +: 8] = 8'(i);
    tbl[3].m = 1'b1; tbl[3].eu_d = 8'h0F; tbl[3].eu_i = 4'd15; tbl[3].es_d = 8'h0F; tbl[3].es_i = 4'd15;
    for (int i = 0; i < 16; i++) tbl[4].w[i*8 +: 8] = 8'h33;
    tbl[4].m = 1'b0; tbl[4].eu_d = 8'h33; tbl[4].eu_i = 4'd0; tbl[4].es_d = 8'h33; tbl[4].es_i = 4'd0;
    for (int i = 0; i < 16; i++) tbl[5].w[i*8 +: 8] = 8'h01;
    tbl[5].w[127:120] = 8'hFF;
    tbl[5].m = 1'b1; tbl[5].eu_d = 8'hFF; tbl[5].eu_i = 4'd15; tbl[5].es_d = 8'h01; tbl[5].es_i = 4'd0;

    rst = 1'b1; clr = 1'b0; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    tick();
    check("ready_during_rst", {31'd0, u_in_ready}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, u_out_valid}, 32'd0);
    check("rst_out_data", {24'd0, u_out_data}, 32'd0);
    check("rst_out_idx", {28'd0, u_out_idx}, 32'd0);
    check("ready_after_rst", {31'd0, u_in_ready}, 32'd1);

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 16; i++) cur[i] = tbl[v].w[i*8 +: 8];
      send_frame(tbl[v].m, 1'b0);
      check($sformatf("v%0d_u_data", v), {24'd0, u_out_data}, {24'd0, tbl[v].eu_d});
      check($sformatf("v%0d_u_idx", v), {28'd0, u_out_idx}, {28'd0, tbl[v].eu_i});
      check($sformatf("v%0d_s_data", v), {24'd0, s_out_data}, {24'd0, tbl[v].es_d});
      check($sformatf("v%0d_s_idx", v), {28'd0, s_out_idx}, {28'd0, tbl[v].es_i});
      ack();
    end

    // Backpressure: HOLD must not consume offered beats.
    for (int i = 0; i < 16; i++) cur[i] = 8'(16 - i);
    send_frame(1'b0, 1'b0);
    in_valid = 1'b1; in_data = 8'h00;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_in_ready", {31'd0, u_in_ready}, 32'd0);
      check("bp_valid", {31'd0, u_out_valid}, 32'd1);
      check("bp_data", {24'd0, u_out_data}, 32'h01);
      check("bp_idx", {28'd0, u_out_idx}, 32'd15);
    end
    ack();
    for (int i = 0; i < 16; i++) cur[i] = 8'(i + 1);
    send_frame(1'b0, 1'b0);
    check("bp_next_data", {24'd0, u_out_data}, 32'h01);
    check("bp_next_idx", {28'd0, u_out_idx}, 32'd0);
    ack();

    // Mode toggled after the first beat must be ignored.
    for (int i = 0; i < 16; i++) cur[i] = 8'(16 - i);
    send_frame(1'b0, 1'b1);
    check("toggle_data", {24'd0, u_out_data}, 32'h01);
    check("toggle_idx", {28'd0, u_out_idx}, 32'd15);
    ack();

    // Abort after beat 7; the beat offered with clr is dropped.
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 8'h00; mode = 1'b0;
      tick();
    end
    clr = 1'b1; in_data = 8'h00;
    tick();
    clr = 1'b0; in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("clr_no_valid", {31'd0, u_out_valid}, 32'd0);
      tick();
    end
    for (int i = 0; i < 16; i++) cur[i] = 8'(8'h20 + i);
    send_frame(1'b0, 1'b0);
    check("clr_next_data", {24'd0, u_out_data}, 32'h20);
    check("clr_next_idx", {28'd0, u_out_idx}, 32'd0);
    ack();

    // Reset after beat 10 drops the partial frame.
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1; in_data = 8'hEE; mode = 1'b1;
      tick();
    end
    rst = 1'b1;
    #1;
    check("midrst_in_ready", {31'd0, u_in_ready}, 32'd0);
    tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("midrst_valid", {31'd0, u_out_valid}, 32'd0);
    check("midrst_data", {24'd0, u_out_data}, 32'd0);
    check("midrst_idx", {28'd0, u_out_idx}, 32'd0);
    for (int i = 0; i < 16; i++) cur[i] = 8'(8'h40 + i);
    send_frame(1'b1, 1'b0);
    check("midrst_next_data", {24'd0, u_out_data}, 32'h4F);
    check("midrst_next_idx", {28'd0, u_out_idx}, 32'd15);
    ack();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
